// File: rtl/thresh_cfg_loader_if.sv
// Threshold stream and config-port bundle for thresh_cfg_loader.
// The master modport is the loader side; slave is the source/target side.
interface thresh_cfg_loader_if #(
  parameter int K = 8,
  parameter int A = 1
);
  logic         s_tvalid;
  logic         s_tready;
  logic [K-1:0] s_tdata;
  logic         cfg_en;
  logic         cfg_we;
  logic [A-1:0] cfg_a;
  logic [K-1:0] cfg_d;
  logic         cfg_rack;
  logic [K-1:0] cfg_q;

  modport master (
    input  s_tvalid, s_tdata, cfg_rack, cfg_q,
    output s_tready, cfg_en, cfg_we, cfg_a, cfg_d
  );

  modport slave (
    output s_tvalid, s_tdata, cfg_rack, cfg_q,
    input  s_tready, cfg_en, cfg_we, cfg_a, cfg_d
  );
endinterface

// File: rtl/thresh_cfg_loader.sv
// Converts a channel-major threshold stream into thresholding config writes at {cf, pe, t}.
// Define THRESH_CFG_LOADER_VERIFY_EN to read back every write and flag mismatches on err.
module thresh_cfg_loader #(
  parameter int N  = 1,
  parameter int K  = 8,
  parameter int C  = 1,
  parameter int PE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                err,
  thresh_cfg_loader_if.master bus
);
  localparam int CF  = C / PE;
  localparam int TW  = $clog2(N);
  localparam int PW  = $clog2(PE);
  localparam int CW  = $clog2(CF);
  localparam int A   = (CW + PW + TW < 1) ? 1 : CW + PW + TW;
  localparam int TCW = (TW < 1) ? 1 : TW;
  localparam int PCW = (PW < 1) ? 1 : PW;
  localparam int CCW = (CW < 1) ? 1 : CW;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WR, S_CHK, S_FIN} state_t;

  state_t         state_q, state_d;
  logic [TCW-1:0] t_q, t_d;
  logic [PCW-1:0] pe_q, pe_d;
  logic [CCW-1:0] cf_q, cf_d;
  logic           cfg_en_q, cfg_en_d;
  logic           cfg_we_q, cfg_we_d;
  logic [A-1:0]   cfg_a_q, cfg_a_d;
  logic [K-1:0]   cfg_d_q, cfg_d_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           is_last;
  logic [A-1:0]   addr;

  // Zero-width fields collapse because their counters stay 0 and their shifts overlap.
  assign addr    = (A'(cf_q) << (PW + TW)) | (A'(pe_q) << TW) | A'(t_q);
  assign is_last = (t_q == TCW'(N - 1)) && (pe_q == PCW'(PE - 1)) && (cf_q == CCW'(CF - 1));

`ifdef THRESH_CFG_LOADER_VERIFY_EN
  logic err_q, err_d;
  logic last_q, last_d;
  assign err = err_q;
`else
  logic unused_readback;
  assign unused_readback = ^{bus.cfg_rack, bus.cfg_q};
  assign err = 1'b0;
`endif

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d  = state_q;
    t_d      = t_q;
    pe_d     = pe_q;
    cf_d     = cf_q;
    cfg_en_d = 1'b0;
    cfg_we_d = 1'b0;
    cfg_a_d  = cfg_a_q;
    cfg_d_d  = cfg_d_q;
`ifdef THRESH_CFG_LOADER_VERIFY_EN
    err_d    = err_q;
    last_d   = last_q;
`endif
    unique case (state_q)
      S_IDLE: if (start) begin
        t_d     = '0;
        pe_d    = '0;
        cf_d    = '0;
        state_d = S_LOAD;
`ifdef THRESH_CFG_LOADER_VERIFY_EN
        err_d   = 1'b0;
`endif
      end
      S_LOAD: if (bus.s_tvalid) begin
        cfg_en_d = 1'b1;
        cfg_we_d = 1'b1;
        cfg_a_d  = addr;
        cfg_d_d  = bus.s_tdata;
        if (t_q == TCW'(N - 1)) begin
          t_d = '0;
          if (pe_q == PCW'(PE - 1)) begin
            pe_d = '0;
            cf_d = (cf_q == CCW'(CF - 1)) ? '0 : cf_q + 1'b1;
          end else begin
            pe_d = pe_q + 1'b1;
          end
        end else begin
          t_d = t_q + 1'b1;
        end
`ifdef THRESH_CFG_LOADER_VERIFY_EN
        last_d  = is_last;
        state_d = S_WR;
`else
        if (is_last) state_d = S_WR;
`endif
      end
      S_WR: begin
`ifdef THRESH_CFG_LOADER_VERIFY_EN
        // Read back the address just written; cfg_a_q is held from the write.
        cfg_en_d = 1'b1;
        state_d  = S_CHK;
`else
        state_d  = S_FIN;
`endif
      end
      S_CHK: begin
`ifdef THRESH_CFG_LOADER_VERIFY_EN
        if (bus.cfg_rack) begin
          if (bus.cfg_q != cfg_d_q) err_d = 1'b1;
          state_d = last_q ? S_FIN : S_LOAD;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);
  assign done_d = (state_d == S_FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      t_q      <= '0;
      pe_q     <= '0;
      cf_q     <= '0;
      cfg_en_q <= 1'b0;
      cfg_we_q <= 1'b0;
      cfg_a_q  <= '0;
      cfg_d_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef THRESH_CFG_LOADER_VERIFY_EN
      err_q    <= 1'b0;
      last_q   <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      state_q  <= state_d;
      t_q      <= t_d;
      pe_q     <= pe_d;
      cf_q     <= cf_d;
      cfg_en_q <= cfg_en_d;
      cfg_we_q <= cfg_we_d;
      cfg_a_q  <= cfg_a_d;
      cfg_d_q  <= cfg_d_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef THRESH_CFG_LOADER_VERIFY_EN
      err_q    <= err_d;
      last_q   <= last_d;
`endif
    end
  end

  assign bus.s_tready = (state_q == S_LOAD);
  assign bus.cfg_en   = cfg_en_q;
  assign bus.cfg_we   = cfg_we_q;
  assign bus.cfg_a    = cfg_a_q;
  assign bus.cfg_d    = cfg_d_q;
  assign busy         = busy_q;
  assign done         = done_q;
endmodule

// File: tb/tb_thresh_cfg_loader.sv
// Self-checking bench for thresh_cfg_loader: a 1x1x1 instance and an N=8, C=12, PE=3 instance.
`timescale 1ns/1ps
module tb_thresh_cfg_loader;
  localparam int K    = 8;
  localparam int N_B  = 8;
  localparam int C_B  = 12;
  localparam int PE_B = 3;
  localparam int CF_B = C_B / PE_B;
  localparam int TW_B = $clog2(N_B);
  localparam int PW_B = $clog2(PE_B);
  localparam int CW_B = $clog2(CF_B);
  localparam int A_B  = TW_B + PW_B + CW_B;
  localparam int W_B  = C_B * N_B;
`ifdef THRESH_CFG_LOADER_VERIFY_EN
  localparam int A_BUSY = 4;
  localparam int A_GAP  = 2;
`else
  localparam int A_BUSY = 3;
  localparam int A_GAP  = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_start = 1'b0, a_busy, a_done, a_err;
  logic b_start = 1'b0, b_busy, b_done, b_err;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  thresh_cfg_loader_if #(.K(K), .A(1))   a_if ();
  thresh_cfg_loader_if #(.K(K), .A(A_B)) b_if ();

  thresh_cfg_loader #(.N(1), .K(K), .C(1), .PE(1)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done), .err(a_err), .bus(a_if)
  );
  thresh_cfg_loader #(.N(N_B), .K(K), .C(C_B), .PE(PE_B)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done), .err(b_err), .bus(b_if)
  );

  logic [K-1:0] words [W_B];
  int wr_base = 0, rd_base = 0, done_base = 0, corrupt_idx = -1;

  // Monitor of dut_b's config port plus a target memory with 2-cycle read latency.
  logic [K-1:0]   mem [1 << A_B];
  logic [A_B-1:0] wr_addr_q [$];
  logic [K-1:0]   wr_data_q [$];
  int             wr_cyc_q  [$];
  logic           wr_err_q  [$];
  logic [A_B-1:0] rd_addr_q [$];
  logic [A_B-1:0] rd_addr;
  int             rd_delay = 0;
  int             done_cnt = 0;

  always @(negedge clk) begin
    b_if.cfg_rack = 1'b0;
    b_if.cfg_q    = '0;
    if (!rst) begin
      if (b_if.cfg_en && b_if.cfg_we) begin
        wr_addr_q.push_back(b_if.cfg_a);
        wr_data_q.push_back(b_if.cfg_d);
        wr_cyc_q.push_back(cyc);
        wr_err_q.push_back(b_err);
        mem[b_if.cfg_a] = b_if.cfg_d;
      end
      if (b_if.cfg_en && !b_if.cfg_we) begin
        rd_addr_q.push_back(b_if.cfg_a);
        rd_addr  = b_if.cfg_a;
        rd_delay = 2;
      end else if (rd_delay > 0) begin
        rd_delay--;
        if (rd_delay == 0) begin
          b_if.cfg_rack = 1'b1;
          b_if.cfg_q    = mem[rd_addr] ^
                          ((rd_addr_q.size() - 1 - rd_base == corrupt_idx) ? 8'h01 : 8'h00);
        end
      end
      if (b_done) done_cnt++;
    end
  end

  function automatic int exp_addr(input int i);
    int c  = i / N_B;
    int t  = i % N_B;
    int cf = c / PE_B;
    int pe = c % PE_B;
    return cf * (1 << (PW_B + TW_B)) + pe * (1 << TW_B) + t;
  endfunction

  task automatic drive_load(input int n, input bit gaps, input int mid_start_idx,
                            input bit start_now, output int start_cyc);
    int idx = 0;
    int k = 0;
    wr_base   = wr_addr_q.size();
    rd_base   = rd_addr_q.size();
    done_base = done_cnt;
    if (!start_now) @(negedge clk);
    checks++;
    if (b_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_before_start: busy=%b, expected 0", b_busy);
    end
    b_start   = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    b_start = 1'b0;
    while (idx < n && k < 4000) begin
      b_if.s_tvalid = gaps ? (k % 2 == 0) : 1'b1;
      b_if.s_tdata  = words[idx];
      b_start       = (mid_start_idx >= 0) && (idx == mid_start_idx);
      if (b_if.s_tvalid && b_if.s_tready) idx++;
      @(negedge clk);
      k++;
    end
    b_if.s_tvalid = 1'b0;
    b_start       = 1'b0;
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL load_accept: accepted %0d words, expected %0d", idx, n);
    end
  endtask

  task automatic wait_done(output int done_at, output logic done_err);
    int k = 0;
    while (b_done !== 1'b1 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    done_at  = cyc;
    done_err = b_err;
    checks++;
    if (b_done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: done=%b after %0d cycles, expected 1", b_done, k);
    end
  endtask

  task automatic check_seq(input string tag, input int n);
    int got   = wr_addr_q.size() - wr_base;
    int shown = 0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL %s_count: %0d write cycles, expected %0d", tag, got, n);
    end
    for (int i = 0; i < n && i < got; i++) begin
      checks++;
      if (wr_addr_q[wr_base+i] !== A_B'(exp_addr(i)) || wr_data_q[wr_base+i] !== words[i]) begin
        errors++;
        if (shown < 4)
          $display("FAIL %s_write[%0d]: a=%0d d=%h, expected a=%0d d=%h", tag, i,
                   wr_addr_q[wr_base+i], wr_data_q[wr_base+i], exp_addr(i), words[i]);
        shown++;
      end
    end
    checks++;
    if (done_cnt - done_base != 1) begin
      errors++;
      $display("FAIL %s_done_pulses: %0d, expected 1", tag, done_cnt - done_base);
    end
`ifdef THRESH_CFG_LOADER_VERIFY_EN
    checks++;
    if (rd_addr_q.size() - rd_base != got) begin
      errors++;
      $display("FAIL %s_reads: %0d reads, expected %0d", tag, rd_addr_q.size() - rd_base, got);
    end else begin
      for (int i = 0; i < got; i++) begin
        checks++;
        if (rd_addr_q[rd_base+i] !== wr_addr_q[wr_base+i]) begin
          errors++;
          $display("FAIL %s_read_addr[%0d]: %0d, expected %0d", tag, i,
                   rd_addr_q[rd_base+i], wr_addr_q[wr_base+i]);
        end
      end
    end
`endif
  endtask

  task automatic check_load(input string tag, input int n);
    repeat (3) @(negedge clk);
    check_seq(tag, n);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({a_busy, a_done, a_err, a_if.s_tready, a_if.cfg_en, a_if.cfg_we, a_if.cfg_a, a_if.cfg_d} !== '0) begin
      errors++;
      $display("FAIL reset_a: outputs=%h, expected 0",
               {a_busy, a_done, a_err, a_if.s_tready, a_if.cfg_en, a_if.cfg_we, a_if.cfg_a, a_if.cfg_d});
    end
    checks++;
    if ({b_busy, b_done, b_err, b_if.s_tready, b_if.cfg_en, b_if.cfg_we, b_if.cfg_a, b_if.cfg_d} !== '0) begin
      errors++;
      $display("FAIL reset_b: outputs=%h, expected 0",
               {b_busy, b_done, b_err, b_if.s_tready, b_if.cfg_en, b_if.cfg_we, b_if.cfg_a, b_if.cfg_d});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (b_if.s_tready !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: tready=%b busy=%b, expected 0 0", b_if.s_tready, b_busy);
    end
  endtask

  task automatic test_single();
    int busy_n = 0, wr_n = 0, done_n = 0, wr_at = -1, done_at = -1;
    bit take;
    @(negedge clk);
    a_start = 1'b1;
    @(negedge clk);
    a_start        = 1'b0;
    a_if.s_tvalid  = 1'b1;
    a_if.s_tdata   = 8'h15;
    for (int i = 0; i < 10; i++) begin
      take   = a_if.s_tvalid && a_if.s_tready;
      busy_n += int'(a_busy);
      if (a_if.cfg_en && a_if.cfg_we) begin
        wr_n++;
        wr_at = i;
        checks++;
        if (a_if.cfg_a !== 1'b0 || a_if.cfg_d !== 8'h15) begin
          errors++;
          $display("FAIL single_write: a=%0d d=%h, expected a=0 d=15", a_if.cfg_a, a_if.cfg_d);
        end
      end
      if (a_done) begin
        done_n++;
        done_at = i;
      end
      @(negedge clk);
      if (take) a_if.s_tvalid = 1'b0;
    end
    checks++;
    if (wr_n != 1 || done_n != 1) begin
      errors++;
      $display("FAIL single_counts: writes=%0d dones=%0d, expected 1 1", wr_n, done_n);
    end
    checks++;
    if (busy_n != A_BUSY) begin
      errors++;
      $display("FAIL single_busy: busy for %0d cycles, expected %0d", busy_n, A_BUSY);
    end
    checks++;
    if (done_at != wr_at + A_GAP) begin
      errors++;
      $display("FAIL single_done_time: done at %0d, expected %0d", done_at, wr_at + A_GAP);
    end
    checks++;
    if (a_if.cfg_en !== 1'b0 || a_if.cfg_d !== 8'h15) begin
      errors++;
      $display("FAIL single_hold: en=%b d=%h, expected en=0 d=15", a_if.cfg_en, a_if.cfg_d);
    end
  endtask

  task automatic test_stream();
    int sc, da;
    logic de;
    drive_load(W_B, 1'b0, -1, 1'b0, sc);
    wait_done(da, de);
    check_load("stream", W_B);
    checks++;
    if (wr_addr_q[wr_base+37] !== A_B'(45)) begin
      errors++;
      $display("FAIL word37_addr: %0d, expected 45", wr_addr_q[wr_base+37]);
    end
`ifndef THRESH_CFG_LOADER_VERIFY_EN
    checks++;
    if (wr_cyc_q[wr_base+W_B-1] - wr_cyc_q[wr_base] != W_B - 1) begin
      errors++;
      $display("FAIL back_to_back: writes span %0d cycles, expected %0d",
               wr_cyc_q[wr_base+W_B-1] - wr_cyc_q[wr_base] + 1, W_B);
    end
    checks++;
    if (da - sc != W_B + 2 || da != wr_cyc_q[wr_base+W_B-1] + 1) begin
      errors++;
      $display("FAIL load_duration: done %0d cycles after start, expected %0d", da - sc, W_B + 2);
    end
`endif
  endtask

  task automatic test_gaps();
    int sc, da;
    logic de;
    drive_load(W_B, 1'b1, -1, 1'b0, sc);
    wait_done(da, de);
    check_load("gaps", W_B);
  endtask

  task automatic test_start_ignored();
    int sc, da;
    logic de;
    drive_load(W_B, 1'b0, 20, 1'b0, sc);
    wait_done(da, de);
    b_start = 1'b1;
    @(negedge clk);
    check_seq("start_mid", W_B);
    drive_load(W_B, 1'b0, -1, 1'b1, sc);
    wait_done(da, de);
    check_load("restart", W_B);
  endtask

  task automatic test_mid_reset();
    int sc, da;
    logic de;
    drive_load(10, 1'b0, -1, 1'b0, sc);
    rst = 1'b1;
    #1;
    checks++;
    if ({b_busy, b_done, b_err, b_if.s_tready, b_if.cfg_en, b_if.cfg_we, b_if.cfg_a, b_if.cfg_d} !== '0) begin
      errors++;
      $display("FAIL mid_reset: outputs=%h, expected 0",
               {b_busy, b_done, b_err, b_if.s_tready, b_if.cfg_en, b_if.cfg_we, b_if.cfg_a, b_if.cfg_d});
    end
    @(negedge clk);
    rst = 1'b0;
    drive_load(W_B, 1'b0, -1, 1'b0, sc);
    wait_done(da, de);
    check_load("after_reset", W_B);
  endtask

`ifdef THRESH_CFG_LOADER_VERIFY_EN
  task automatic test_verify();
    int sc, da;
    logic de;
    corrupt_idx = 3;
    drive_load(W_B, 1'b0, -1, 1'b0, sc);
    wait_done(da, de);
    check_load("verify_bad", W_B);
    checks++;
    if (wr_err_q[wr_base+3] !== 1'b0 || wr_err_q[wr_base+4] !== 1'b1) begin
      errors++;
      $display("FAIL err_rise: err at write3=%b write4=%b, expected 0 1",
               wr_err_q[wr_base+3], wr_err_q[wr_base+4]);
    end
    checks++;
    if (de !== 1'b1 || b_err !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: err at done=%b after=%b, expected 1 1", de, b_err);
    end
    corrupt_idx = -1;
    drive_load(W_B, 1'b1, -1, 1'b0, sc);
    wait_done(da, de);
    check_load("verify_good", W_B);
    checks++;
    if (wr_err_q[wr_base] !== 1'b0 || de !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err at first write=%b at done=%b, expected 0 0", wr_err_q[wr_base], de);
    end
  endtask
`else
  task automatic test_no_verify();
    checks++;
    if (a_err !== 1'b0 || b_err !== 1'b0 || rd_addr_q.size() != 0) begin
      errors++;
      $display("FAIL no_readback: err=%b%b reads=%0d, expected 00 0", a_err, b_err, rd_addr_q.size());
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < W_B; i++) words[i] = K'($urandom);
    a_if.s_tvalid = 1'b0;
    a_if.s_tdata  = '0;
    a_if.cfg_rack = 1'b1;
    a_if.cfg_q    = 8'h15;
    b_if.s_tvalid = 1'b0;
    b_if.s_tdata  = '0;
    test_reset();
    test_single();
    test_stream();
    test_gaps();
    test_start_ignored();
    test_mid_reset();
`ifdef THRESH_CFG_LOADER_VERIFY_EN
    test_verify();
`else
    test_no_verify();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/thresh_cfg_loader.md
# thresh_cfg_loader

Streams threshold values into the configuration port of a `thresholding` instance. It sits directly upstream of that port: it converts a channel-major AXI-Stream of threshold words into `cfg_en`/`cfg_we`/`cfg_a`/`cfg_d` write cycles, generating the packed `{cf, pe, t}` address automatically. An optional readback check confirms every write through `cfg_rack`/`cfg_q`.

## Interface
Parameters:
- `N`, 1: thresholds per channel.
- `K`, 8: threshold word width.
- `C`, 1: channel count; must be divisible by `PE`.
- `PE`, 1: parallel PEs of the target; `CF = C/PE`.
- Address width `A = clog2(CF) + clog2(PE) + clog2(N)`.
  - Zero-width fields are omitted.
  - The minimum width is 1 bit.

Ports:
- `clk`  in  1  clock; the only clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `start`  in  1  single-cycle request to begin a load.
- `busy`  out  1  high from acceptance of `start` until `done`.
- `done`  out  1  one-cycle pulse when the load completes.
- `err`  out  1  sticky readback mismatch flag.
- `s_tvalid`  in  1  threshold word valid.
- `s_tready`  out  1  loader accepts a word.
- `s_tdata`  in  K  threshold word.
- `cfg_en`  out  1  config access enable.
- `cfg_we`  out  1  1 = write, 0 = read.
- `cfg_a`  out  A  address, packed `{cf, pe, t}` with `t` in the LSBs.
- `cfg_d`  out  K  write data.
- `cfg_rack`  in  1  readback reply valid.
- `cfg_q`  in  K  readback data.

## Operation
- Input order is channel-major: channel 0 thresholds t = 0..N-1, then channel 1, and so on. Total words per load: C·N.
- Channel c maps to `cf = c / PE` and `pe = c % PE`.
- Three counters are kept: `t` (0..N-1), `pe` (0..PE-1) and `cf` (0..CF-1).
  - `t` increments on each accepted word.
  - When `t` wraps, `pe` increments.
  - When `pe` wraps, `cf` increments.
- States:
  - IDLE: `s_tready`=0. `start`=1 clears the counters and `err`, then moves to LOAD.
  - LOAD: `s_tready`=1. On `s_tvalid && s_tready`, register `cfg_en`=1, `cfg_we`=1, `cfg_a`={cf,pe,t} and `cfg_d`=`s_tdata` for exactly one cycle, then advance the counters. When the accepted word is the last one (cf=CF-1, pe=PE-1, t=N-1), move to FIN.
  - FIN: `done`=1 for one cycle, then IDLE.
  - CHK (only with the macro enabled): see Configuration.
- Outside a write or read cycle: `cfg_en`=0 and `cfg_we`=0. `cfg_a` and `cfg_d` hold their last values.
- `start` is ignored whenever the state is not IDLE.
- `busy` is high in every state except IDLE.
- Reset, including mid-load: all outputs go to 0 immediately and the state returns to IDLE. The target is left partially written. The next `start` restarts the load at address 0.

## Timing
- Every output is registered except `s_tready`, which is decoded from the state register.
- Reset value of every output is 0.
- An accepted word at edge k appears on the cfg port during cycle k+1.
- Without readback checking, throughput is one word per cycle; back-to-back words produce back-to-back write cycles.
- When `s_tvalid` is low in LOAD, no cfg access occurs and the counters hold.
- `done` is high in the cycle after the final write cycle. `busy` falls in that same cycle.
- Minimum load duration: C·N + 2 cycles from `start` to `done`.

## Configuration
- Macro: `THRESH_CFG_LOADER_VERIFY_EN`.
- With the macro defined:
  - After each write cycle, the following cycle issues a read (`cfg_en`=1, `cfg_we`=0, same `cfg_a`).
  - The state then moves to CHK with `s_tready`=0.
  - CHK waits, without timeout, for `cfg_rack`=1.
  - If `cfg_q` ≠ the written word, `err` is set.
  - CHK then returns to LOAD, or to FIN after the last word.
  - Throughput becomes at most one word per (3 + read latency) cycles.
  - `err` stays set until the next accepted `start` or reset.
- Without the macro: no read is issued, `cfg_rack`/`cfg_q` are ignored and `err` is tied to 0.

## Test plan
- N=1, C=1, PE=1: `start`, then one word 0x15 → exactly one write cycle with `cfg_a`=0 and `cfg_d`=0x15; `done` in the next cycle; `busy` high for 3 cycles.
- N=8, C=12, PE=3, continuous valid, 96 words → 96 back-to-back write cycles. Word #37 (c=4, t=5) → `cfg_a`=45 (cf=1, pe=1, t=5). `done` is a single pulse.
- Same configuration with `s_tvalid` low every other cycle → write cycles only for accepted words; the address sequence is unchanged; no duplicate or skipped address.
- `start` pulsed during LOAD and in the FIN cycle → ignored, no restart. `start` in the following IDLE cycle → a new load beginning at address 0.
- `rst` asserted after 10 of 96 words → all outputs 0 asynchronously. A new `start` with 96 words completes normally with addresses starting at 0.
- Macro enabled, target model with 2-cycle read latency returning a corrupted word for index 3 → `err` rises after the 4th check and stays high through `done`. No mismatch → `err`=0. The next `start` clears `err`.
